// File: rtl/rstn_release_sequencer.sv
// Reset release sequencer: drives the RN pins of NUM_DOM reset domains.
// Chip RN low clears every domain at once; on RN release the deassertion is
// synchronized and the domains are released one by one in index order, with
// a gap of DLY+1 cycles ahead of each release.
// Optional feature macro: RSTSEQ_SOFT_EN (soft reset via SOFT_REQ/SOFT_ACK
// 4-phase handshake). Without it, RUN is terminal until RN goes low.
module rstn_release_sequencer #(
   parameter int unsigned NUM_DOM     = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DLY_W       = 4
) (
   input  logic               CLK,
   input  logic               RN,
   input  logic [DLY_W-1:0]   DLY,
`ifdef RSTSEQ_SOFT_EN
   input  logic               SOFT_REQ,
   output logic               SOFT_ACK,
`endif
   output logic [NUM_DOM-1:0] RN_OUT,
   output logic               BUSY,
   output logic               DONE
);

   localparam int unsigned IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
   // The final synchronizer stage is the FSM state register itself, so the
   // RST->GAP move lands on edge SYNC_STAGES after RN rises.
   localparam int unsigned PRE_W = SYNC_STAGES - 1;

   typedef enum logic [1:0] {StRst, StGap, StRun, StSoft} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DLY_W-1:0]    cnt_q, cnt_d;
   logic [DLY_W-1:0]    dly_q, dly_d;
   logic [NUM_DOM-1:0]  rn_out_q, rn_out_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [PRE_W-1:0]    sync_q;
   logic                sync_go;
`ifdef RSTSEQ_SOFT_EN
   logic                ack_q, ack_d;
`endif

   // Deassertion synchronizer: cleared by RN, shifts in ones.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= 1'b1;
         for (int i = 1; i < int'(PRE_W); i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign sync_go = sync_q[PRE_W-1];

   // State and registered outputs.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_q  <= StRst;
         idx_q    <= '0;
         cnt_q    <= '0;
         dly_q    <= '0;
         rn_out_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef RSTSEQ_SOFT_EN
         ack_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         dly_q    <= dly_d;
         rn_out_q <= rn_out_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef RSTSEQ_SOFT_EN
         ack_q    <= ack_d;
`endif
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      dly_d    = dly_q;
      rn_out_d = rn_out_q;
      busy_d   = busy_q;
      done_d   = done_q;
`ifdef RSTSEQ_SOFT_EN
      ack_d    = ack_q;
`endif
      unique case (state_q)
         StRst: begin
            if (sync_go) begin
               state_d = StGap;
               dly_d   = DLY;
               cnt_d   = DLY;
               idx_d   = '0;
               busy_d  = 1'b1;
            end
         end
         StGap: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - DLY_W'(1);
            end else begin
               rn_out_d[idx_q] = 1'b1;
               if (idx_q == IDX_W'(NUM_DOM - 1)) begin
                  state_d = StRun;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  cnt_d = dly_q;
               end
            end
         end
         StRun: begin
`ifdef RSTSEQ_SOFT_EN
            if (SOFT_REQ) begin
               state_d  = StSoft;
               rn_out_d = '0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               ack_d    = 1'b1;
            end
`endif
         end
         StSoft: begin
`ifdef RSTSEQ_SOFT_EN
            // Request dropped: restart release without re-running the synchronizer.
            if (!SOFT_REQ) begin
               state_d = StGap;
               ack_d   = 1'b0;
               dly_d   = DLY;
               cnt_d   = DLY;
               idx_d   = '0;
            end
`else
            state_d = StRst;
`endif
         end
         default: state_d = StRst;
      endcase
   end

   assign RN_OUT = rn_out_q;
   assign BUSY   = busy_q;
   assign DONE   = done_q;
`ifdef RSTSEQ_SOFT_EN
   assign SOFT_ACK = ack_q;
`endif

endmodule

// File: tb/tb_rstn_release_sequencer.sv
// Directed bench for rstn_release_sequencer (default parameters).
// Soft-reset scenarios are compiled in when RSTSEQ_SOFT_EN is defined.
module tb_rstn_release_sequencer;

   localparam int NUM_DOM = 4;
   localparam int SYNC    = 2;
   localparam int DLY_W   = 4;

   logic               CLK = 1'b0;
   logic               RN  = 1'b0;
   logic [DLY_W-1:0]   DLY = 4'd3;
   logic [NUM_DOM-1:0] RN_OUT;
   logic               BUSY;
   logic               DONE;
`ifdef RSTSEQ_SOFT_EN
   logic               SOFT_REQ = 1'b0;
   logic               SOFT_ACK;
`endif

   int total = 0;
   int bad   = 0;

   rstn_release_sequencer #(
      .NUM_DOM     (NUM_DOM),
      .SYNC_STAGES (SYNC),
      .DLY_W       (DLY_W)
   ) dut (
      .CLK      (CLK),
      .RN       (RN),
      .DLY      (DLY),
`ifdef RSTSEQ_SOFT_EN
      .SOFT_REQ (SOFT_REQ),
      .SOFT_ACK (SOFT_ACK),
`endif
      .RN_OUT   (RN_OUT),
      .BUSY     (BUSY),
      .DONE     (DONE)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Follow a release sequence edge by edge from an RN rise placed mid-cycle.
   task automatic seq(input int dly, input int chg_at, input int new_dly, input int stop_at);
      int last;
      logic [NUM_DOM-1:0] exp;
      last = SYNC + NUM_DOM * (dly + 1);
      for (int e = 1; e <= last; e++) begin
         @(posedge CLK);
         #1;
         exp = '0;
         for (int k = 0; k < NUM_DOM; k++) begin
            if (e >= SYNC + (k + 1) * (dly + 1)) exp[k] = 1'b1;
         end
         check($sformatf("rn_out d%0d e%0d", dly, e), 32'(RN_OUT), 32'(exp));
         check($sformatf("busy d%0d e%0d", dly, e), 32'(BUSY), 32'(e >= SYNC && e < last));
         check($sformatf("done d%0d e%0d", dly, e), 32'(DONE), 32'(e >= last));
`ifdef RSTSEQ_SOFT_EN
         check($sformatf("ack d%0d e%0d", dly, e), 32'(SOFT_ACK), 32'(0));
`endif
         if (e == chg_at) DLY = DLY_W'(new_dly);
         if (e == stop_at) return;
      end
   endtask

   // Short RN pulse starting just after an edge, ending before the next one.
   task automatic pulse_rn();
      RN = 1'b0;
      #1;
      check("pulse rn_out", 32'(RN_OUT), 32'(0));
      check("pulse busy", 32'(BUSY), 32'(0));
      check("pulse done", 32'(DONE), 32'(0));
`ifdef RSTSEQ_SOFT_EN
      check("pulse ack", 32'(SOFT_ACK), 32'(0));
`endif
      #2;
      RN = 1'b1;
   endtask

   initial begin
      #12;
      check("reset rn_out", 32'(RN_OUT), 32'(0));
      check("reset busy", 32'(BUSY), 32'(0));
      check("reset done", 32'(DONE), 32'(0));

      // DLY=3, changed to 9 after edge 7: timing must stay 6/10/14/18.
      @(negedge CLK);
      RN = 1'b1;
      seq(3, 7, 9, 0);
      DLY = 4'd3;
      @(posedge CLK);
      #1;
      check("run hold rn_out", 32'(RN_OUT), 32'hf);
      check("run hold done", 32'(DONE), 32'(1));
      check("run hold busy", 32'(BUSY), 32'(0));

      // Restart, then interrupt with a sub-cycle RN pulse after edge 12.
      pulse_rn();
      seq(3, 0, 0, 12);
      pulse_rn();
      seq(3, 0, 0, 0);

      // DLY=0: releases on consecutive edges 3..6.
      DLY = 4'd0;
      pulse_rn();
      seq(0, 0, 0, 0);

`ifdef RSTSEQ_SOFT_EN
      // Soft reset from RUN with DLY=1.
      DLY = 4'd1;
      SOFT_REQ = 1'b1;
      for (int j = 1; j <= 5; j++) begin
         @(posedge CLK);
         #1;
         check($sformatf("soft ack j%0d", j), 32'(SOFT_ACK), 32'(1));
         check($sformatf("soft rn_out j%0d", j), 32'(RN_OUT), 32'(0));
         check($sformatf("soft busy j%0d", j), 32'(BUSY), 32'(1));
         check($sformatf("soft done j%0d", j), 32'(DONE), 32'(0));
      end
      SOFT_REQ = 1'b0;
      @(posedge CLK);
      #1;
      check("soft drop ack", 32'(SOFT_ACK), 32'(0));
      check("soft drop rn_out", 32'(RN_OUT), 32'(0));
      check("soft drop busy", 32'(BUSY), 32'(1));
      for (int j = 1; j <= 8; j++) begin
         logic [NUM_DOM-1:0] exp;
         @(posedge CLK);
         #1;
         exp = '0;
         for (int k = 0; k < NUM_DOM; k++) begin
            if (j >= 2 * (k + 1)) exp[k] = 1'b1;
         end
         check($sformatf("resoft rn_out j%0d", j), 32'(RN_OUT), 32'(exp));
         check($sformatf("resoft done j%0d", j), 32'(DONE), 32'(j >= 8));
         check($sformatf("resoft ack j%0d", j), 32'(SOFT_ACK), 32'(0));
      end

      // Request held from RN release: not acknowledged until after DONE.
      DLY = 4'd3;
      SOFT_REQ = 1'b1;
      pulse_rn();
      seq(3, 0, 0, 0);
      @(posedge CLK);
      #1;
      check("held ack", 32'(SOFT_ACK), 32'(1));
      check("held rn_out", 32'(RN_OUT), 32'(0));
      check("held done", 32'(DONE), 32'(0));
      SOFT_REQ = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rstn_release_sequencer.md
Name: rstn_release_sequencer

Overview:
- Controls the asynchronous-reset pins (RN) of banks of reset flip-flops (dffrnq-class cells), grouped into NUM_DOM reset domains.
- Applies reset to all domains immediately when the chip-level RN goes low.
- On RN release, synchronizes the deassertion, then releases the domains one at a time in index order, with a programmable gap between releases.
- Optionally supports a software-requested soft reset through a 4-phase handshake. Sits between the pad/POR reset and the register banks.

Parameters:
- NUM_DOM, 4, number of reset domains (RN_OUT width); legal range 1..16.
- SYNC_STAGES, 2, depth of the deassertion synchronizer; minimum 2.
- DLY_W, 4, width of the DLY gap input.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RN  input  1  reset, asynchronous and active-low.
- DLY  input  DLY_W  gap length in cycles minus one; latched at sequence start.
- SOFT_REQ  input  1  soft-reset request, level (present only with RSTSEQ_SOFT_EN).
- SOFT_ACK  output  1  soft-reset acknowledge (present only with RSTSEQ_SOFT_EN).
- RN_OUT  output  NUM_DOM  per-domain active-low reset; bit k drives domain k.
- BUSY  output  1  sequencing or soft reset in progress.
- DONE  output  1  all domains released.

Behaviour:
- RN low, asynchronously and at any time:
  - RN_OUT=0, DONE=0, BUSY=0, SOFT_ACK=0.
  - Synchronizer chain cleared, state=RST, idx=0, cnt=0.
- Synchronizer: a SYNC_STAGES-deep shift chain. It is asynchronously cleared by RN and shifts in 1 on each edge. Its output sync_rn is high at edge SYNC_STAGES after RN rises.
- States:
  - RST: when sync_rn=1, go to GAP; set dly_q=DLY, cnt=DLY, idx=0.
  - GAP: BUSY=1.
    - If cnt!=0: cnt decrements.
    - If cnt==0: set RN_OUT[idx]=1.
    - After that release: if idx==NUM_DOM-1, go to RUN; otherwise idx increments and cnt=dly_q.
  - RUN: DONE=1, BUSY=0, RN_OUT all ones.
  - SOFT: RN_OUT=0, BUSY=1, DONE=0, SOFT_ACK=1.
- Timing: counting edges from RN rise, domain k is released at edge SYNC_STAGES+(k+1)*(DLY+1). DONE and the last release happen on the same edge.
- All outputs are registered. RN_OUT bits only ever go 0->1 in index order, except on reset or soft reset.
- DLY changes during GAP are ignored; dly_q is used. DLY=0 gives releases on consecutive edges.
- RN pulse of any length, including one shorter than a cycle: all state is cleared and the sequence restarts from RST.
- With NUM_DOM=1, RUN is reached after the single release.

Optional Feature:
- Macro RSTSEQ_SOFT_EN.
- Defined:
  - SOFT_REQ/SOFT_ACK ports exist.
  - In RUN, SOFT_REQ=1 sampled at an edge: go to SOFT on that edge, with RN_OUT=0 and SOFT_ACK=1 at its output.
  - Stay in SOFT while SOFT_REQ=1.
  - SOFT_REQ=0 sampled in SOFT: SOFT_ACK=0, go to GAP with dly_q=DLY, cnt=DLY, idx=0. The synchronizer is not re-run.
  - SOFT_REQ high during RST/GAP is not acknowledged until RUN is reached.
- Undefined: ports absent and RUN is terminal until RN goes low.

Test Plan:
- Defaults, DLY=3, RN released before edge 1 -> RN_OUT bits 0..3 go high at edges 6, 10, 14, 18; DONE=1 and BUSY=0 from edge 18; BUSY=1 on edges 2..17.
- DLY=0, NUM_DOM=4 -> releases at edges 3, 4, 5, 6; DONE at edge 6.
- Sequence running with DLY=3; DLY changed to 9 after edge 7 -> release timing unchanged (10, 14, 18).
- RN pulsed low for half a cycle after edge 12 -> RN_OUT=0, BUSY=0, DONE=0 immediately; release pattern restarts, first bit high 6 edges after the pulse ends.
- RSTSEQ_SOFT_EN, in RUN: SOFT_REQ=1 for 5 cycles, then 0, DLY=1 -> SOFT_ACK high and RN_OUT=0 on the edge after the request; SOFT_ACK low on the edge after request removal; bits re-released at +2, +4, +6, +8 edges; DONE again.
- RSTSEQ_SOFT_EN: SOFT_REQ held high from RN release -> no ACK until DONE; SOFT entered the edge after DONE.
